// File: rtl/mem_arbiter_pkg.sv
// Purpose: shared encodings for the core-to-cache request port and the arbiter FSM.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    localparam int IOSTATEWIDTH = 2;
    localparam int ADDRWIDTH    = 16;
    localparam int WORDWIDTH    = 32;

    // Request encodings on an rw field; the fourth code is treated as no request.
    localparam logic [IOSTATEWIDTH-1:0] IDEL = 2'd0;
    localparam logic [IOSTATEWIDTH-1:0] RD   = 2'd1;
    localparam logic [IOSTATEWIDTH-1:0] WT   = 2'd2;

    typedef enum logic [1:0] {
        MEMARB_IDLE    = 2'd0,
        MEMARB_BUSY    = 2'd1,
        MEMARB_RELEASE = 2'd2
    } memarb_state_t;

    function automatic logic is_req(input logic [IOSTATEWIDTH-1:0] rw);
        return (rw == RD) || (rw == WT);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Purpose: round-robin priority search; first requester after 'last' (wrapping) wins.
// Latency: purely combinational.
// Backpressure: none; vld is low when no request bit is set.
//
// Ports: req    - one request bit per port
//        last   - index of the previously granted port (lowest priority now)
//        winner - selected port index, valid when vld=1
//        vld    - at least one request present
module rr_picker #(
    parameter int NPORT = 4,
    parameter int PORTW = 2
) (
    input  logic [NPORT-1:0] req,
    input  logic [PORTW-1:0] last,
    output logic [PORTW-1:0] winner,
    output logic             vld
);

    logic [PORTW-1:0] cand;

    always_comb begin
        winner = last;
        vld    = 1'b0;
        cand   = '0;
        // Offset NPORT wraps back to 'last' itself, so a lone requester is still served.
        for (int off = 1; off <= NPORT; off++) begin
            cand = PORTW'((int'(last) + off) % NPORT);
            if (!vld && req[cand]) begin
                vld    = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: share one cache request port among NPORT cores, round-robin, grant locked per transaction.
// Latency: request seen in cycle N drives rwToMem from N+1; done strobes are same-cycle as rdEn/wtEn.
// Backpressure: cores hold rw until their strobe; a watchdog aborts a stalled access after TIMEOUT cycles.
//
// Ports: rwFromCpu/addrFromCpu/dataFromCpu - per-port requests, port i in slice i
//        rdEnToCpu/wtEnToCpu               - per-port done strobes (only the granted bit can rise)
//        dataToCpu                         - memory read data, broadcast
//        rwToMem/addrToMem/dataToMem       - registered request to memory
//        rdEn/wtEn/dataFromMem             - memory completion and read data
//        grantIdx/busy/timeoutErr          - status; timeoutErr is sticky until reset
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NPORT   = 4,
    parameter int PORTW   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NPORT*IOSTATEWIDTH-1:0] rwFromCpu,
    input  logic [NPORT*ADDRWIDTH-1:0]    addrFromCpu,
    input  logic [NPORT*WORDWIDTH-1:0]    dataFromCpu,
    output logic [NPORT-1:0]              rdEnToCpu,
    output logic [NPORT-1:0]              wtEnToCpu,
    output logic [WORDWIDTH-1:0]          dataToCpu,
    output logic [IOSTATEWIDTH-1:0]       rwToMem,
    output logic [ADDRWIDTH-1:0]          addrToMem,
    output logic [WORDWIDTH-1:0]          dataToMem,
    input  logic                          rdEn,
    input  logic                          wtEn,
    input  logic [WORDWIDTH-1:0]          dataFromMem,
    output logic [PORTW-1:0]              grantIdx,
    output logic                          busy,
    output logic                          timeoutErr
);

    // Counter only needs to reach TIMEOUT-1: expiry fires on the TIMEOUT-th BUSY cycle.
    localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    memarb_state_t state, state_nxt;

    logic [NPORT-1:0]        req;
    logic [PORTW-1:0]        pick;
    logic                    pick_vld;
    logic [IOSTATEWIDTH-1:0] sel_rw;
    logic [ADDRWIDTH-1:0]    sel_addr;
    logic [WORDWIDTH-1:0]    sel_data;
    logic [CNTW-1:0]         cnt;
    logic                    done;
    logic                    expire;

    always_comb begin
        req = '0;
        for (int i = 0; i < NPORT; i++) begin
            req[i] = is_req(rwFromCpu[i*IOSTATEWIDTH +: IOSTATEWIDTH]);
        end
    end

    rr_picker #(
        .NPORT (NPORT),
        .PORTW (PORTW)
    ) u_picker (
        .req    (req),
        .last   (grantIdx),
        .winner (pick),
        .vld    (pick_vld)
    );

    // Winner's request fields, captured into the memory-side registers on grant.
    always_comb begin
        sel_rw   = IDEL;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (PORTW'(i) == pick) begin
                sel_rw   = rwFromCpu[i*IOSTATEWIDTH +: IOSTATEWIDTH];
                sel_addr = addrFromCpu[i*ADDRWIDTH +: ADDRWIDTH];
                sel_data = dataFromCpu[i*WORDWIDTH +: WORDWIDTH];
            end
        end
    end

    // Only the enable matching the outstanding op completes it; a crossed enable is ignored.
    assign done   = ((rwToMem == RD) && rdEn) || ((rwToMem == WT) && wtEn);
    assign expire = (TIMEOUT != 0) && (cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MEMARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            MEMARB_IDLE:    if (pick_vld) state_nxt = MEMARB_BUSY;
            MEMARB_BUSY:    if (done || expire) state_nxt = MEMARB_RELEASE;
            MEMARB_RELEASE: state_nxt = MEMARB_IDLE;
            default:        state_nxt = MEMARB_IDLE;
        endcase
    end

    // Registered memory request, grant index, watchdog and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rwToMem    <= IDEL;
            addrToMem  <= '0;
            dataToMem  <= '0;
            grantIdx   <= PORTW'(NPORT - 1);
            busy       <= 1'b0;
            timeoutErr <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                MEMARB_IDLE: begin
                    if (pick_vld) begin
                        grantIdx  <= pick;
                        rwToMem   <= sel_rw;
                        addrToMem <= sel_addr;
                        dataToMem <= sel_data;
                        busy      <= 1'b1;
                        cnt       <= '0;
                    end
                end
                MEMARB_BUSY: begin
                    // Completion takes precedence over a watchdog expiry in the same cycle.
                    if (done) begin
                        rwToMem <= IDEL;
                        busy    <= 1'b0;
                    end else if (expire) begin
                        rwToMem    <= IDEL;
                        busy       <= 1'b0;
                        timeoutErr <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output logic: done strobes steered to the granted port, same cycle as memory enable.
    always_comb begin
        rdEnToCpu = '0;
        wtEnToCpu = '0;
        if (state == MEMARB_BUSY) begin
            if (rwToMem == RD) rdEnToCpu[grantIdx] = rdEn;
            if (rwToMem == WT) wtEnToCpu[grantIdx] = wtEn;
        end
    end

    assign dataToCpu = dataFromMem;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: randomized core/memory traffic against a transaction-level reference of the arbiter.
// Latency: checks every cycle on the falling edge; inputs change 1 time unit after the rising edge.
// Backpressure: modelled cores hold requests until strobed; modelled memory may stall forever.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int NP  = 4;
    localparam int PW  = 2;
    localparam int TO  = 8;
    localparam int NCYC = 5000;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NP*IOSTATEWIDTH-1:0] rwFromCpu;
    logic [NP*ADDRWIDTH-1:0]    addrFromCpu;
    logic [NP*WORDWIDTH-1:0]    dataFromCpu;
    logic [NP-1:0]              rdEnToCpu;
    logic [NP-1:0]              wtEnToCpu;
    logic [WORDWIDTH-1:0]       dataToCpu;
    logic [IOSTATEWIDTH-1:0]    rwToMem;
    logic [ADDRWIDTH-1:0]       addrToMem;
    logic [WORDWIDTH-1:0]       dataToMem;
    logic                       rdEn;
    logic                       wtEn;
    logic [WORDWIDTH-1:0]       dataFromMem;
    logic [PW-1:0]              grantIdx;
    logic                       busy;
    logic                       timeoutErr;

    mem_arbiter #(
        .NPORT   (NP),
        .PORTW   (PW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rwFromCpu   (rwFromCpu),
        .addrFromCpu (addrFromCpu),
        .dataFromCpu (dataFromCpu),
        .rdEnToCpu   (rdEnToCpu),
        .wtEnToCpu   (wtEnToCpu),
        .dataToCpu   (dataToCpu),
        .rwToMem     (rwToMem),
        .addrToMem   (addrToMem),
        .dataToMem   (dataToMem),
        .rdEn        (rdEn),
        .wtEn        (wtEn),
        .dataFromMem (dataFromMem),
        .grantIdx    (grantIdx),
        .busy        (busy),
        .timeoutErr  (timeoutErr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc_now = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc_now, got, exp);
        end
    endtask

    // Core agents: each holds its request until acknowledged, then drops for at least one cycle.
    logic [IOSTATEWIDTH-1:0] c_rw   [NP];
    logic [ADDRWIDTH-1:0]    c_addr [NP];
    logic [WORDWIDTH-1:0]    c_data [NP];
    bit                      c_act  [NP];
    bit                      c_ack  [NP];

    // Reference: at most one outstanding transaction, then one dead cycle before the next grant.
    bit                      m_pend;
    bit                      m_cool;
    bit                      m_terr;
    int                      m_port;
    int                      m_last;
    int                      m_age;
    int                      mem_lat;
    logic [IOSTATEWIDTH-1:0] m_op;
    logic [ADDRWIDTH-1:0]    m_addr;
    logic [WORDWIDTH-1:0]    m_data;

    task automatic model_reset();
        m_pend = 1'b0;
        m_cool = 1'b0;
        m_terr = 1'b0;
        m_last = NP - 1;
        m_port = 0;
        m_age  = 0;
        m_op   = IDEL;
        m_addr = '0;
        m_data = '0;
        for (int i = 0; i < NP; i++) c_ack[i] = 1'b0;
    endtask

    task automatic drive_cores();
        for (int i = 0; i < NP; i++) begin
            if (c_ack[i]) begin
                c_ack[i] = 1'b0;
                c_act[i] = 1'b0;
                c_rw[i]  = ($urandom_range(0, 1) != 0) ? IDEL : 2'b11;
            end else if (!c_act[i] && $urandom_range(0, 2) == 0) begin
                c_act[i]  = 1'b1;
                c_rw[i]   = ($urandom_range(0, 1) != 0) ? RD : WT;
                c_addr[i] = ADDRWIDTH'($urandom);
                c_data[i] = WORDWIDTH'($urandom);
            end else if (!c_act[i]) begin
                c_rw[i] = ($urandom_range(0, 3) != 0) ? IDEL : 2'b11;
            end
            // The granted core's fields may wander mid-transaction; memory must not see it.
            if (m_pend && m_port == i && $urandom_range(0, 3) == 0) begin
                c_addr[i] = ADDRWIDTH'($urandom);
                c_data[i] = WORDWIDTH'($urandom);
            end
            rwFromCpu[i*IOSTATEWIDTH +: IOSTATEWIDTH] = c_rw[i];
            addrFromCpu[i*ADDRWIDTH +: ADDRWIDTH]     = c_addr[i];
            dataFromCpu[i*WORDWIDTH +: WORDWIDTH]     = c_data[i];
        end
    endtask

    task automatic drive_mem();
        rdEn = 1'b0;
        wtEn = 1'b0;
        if (m_pend) begin
            if (m_age == mem_lat) begin
                if (m_op == RD) rdEn = 1'b1;
                else            wtEn = 1'b1;
            end
            // Crossed enable: must neither strobe nor complete.
            if ($urandom_range(0, 4) == 0) begin
                if (m_op == RD) wtEn = 1'b1;
                else            rdEn = 1'b1;
            end
        end else begin
            rdEn = ($urandom_range(0, 4) == 0);
            wtEn = ($urandom_range(0, 4) == 0);
        end
        dataFromMem = WORDWIDTH'($urandom);
    endtask

    task automatic check_and_advance();
        logic [NP-1:0] exp_rd;
        logic [NP-1:0] exp_wt;
        bit            match;
        bit            found;
        int            p;
        exp_rd = '0;
        exp_wt = '0;
        match  = 1'b0;
        found  = 1'b0;
        p      = 0;
        if (m_pend) begin
            if (m_op == RD && rdEn) exp_rd = NP'(1) << m_port;
            if (m_op == WT && wtEn) exp_wt = NP'(1) << m_port;
            match = (exp_rd != '0) || (exp_wt != '0);
        end
        chk("rwToMem",    rwToMem,    m_pend ? m_op : IDEL);
        chk("addrToMem",  addrToMem,  m_addr);
        chk("dataToMem",  dataToMem,  m_data);
        chk("busy",       busy,       m_pend);
        chk("grantIdx",   grantIdx,   m_last);
        chk("timeoutErr", timeoutErr, m_terr);
        chk("rdEnToCpu",  rdEnToCpu,  exp_rd);
        chk("wtEnToCpu",  wtEnToCpu,  exp_wt);
        chk("dataToCpu",  dataToCpu,  dataFromMem);

        if (m_pend) begin
            if (match) begin
                m_pend = 1'b0;
                m_cool = 1'b1;
                c_ack[m_port] = 1'b1;
            end else begin
                m_age++;
                if (m_age == TO) begin
                    m_pend = 1'b0;
                    m_cool = 1'b1;
                    m_terr = 1'b1;
                end
            end
        end else if (m_cool) begin
            m_cool = 1'b0;
        end else begin
            for (int k = 1; k <= NP; k++) begin
                if (!found) begin
                    p = (m_last + k) % NP;
                    if (c_rw[p] == RD || c_rw[p] == WT) found = 1'b1;
                end
            end
            if (found) begin
                m_pend = 1'b1;
                m_port = p;
                m_last = p;
                m_op   = c_rw[p];
                m_addr = c_addr[p];
                m_data = c_data[p];
                m_age  = 0;
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: mem_lat = $urandom_range(0, 4);
                    6, 7:             mem_lat = TO - 1;   // enable coincides with expiry
                    default:          mem_lat = 1000;     // never acknowledges
                endcase
            end
        end
    endtask

    // Asynchronous reset while a transaction is outstanding, both enables forced high.
    task automatic mid_reset();
        #2;
        rdEn  = 1'b1;
        wtEn  = 1'b1;
        reset = 1'b1;
        #1;
        chk("rst_rwToMem",    rwToMem,    IDEL);
        chk("rst_busy",       busy,       1'b0);
        chk("rst_rdEnToCpu",  rdEnToCpu,  '0);
        chk("rst_wtEnToCpu",  wtEnToCpu,  '0);
        chk("rst_grantIdx",   grantIdx,   NP - 1);
        chk("rst_timeoutErr", timeoutErr, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    int rst_at [2] = '{1500, 3500};
    int rst_idx = 0;

    initial begin
        reset       = 1'b1;
        rwFromCpu   = '0;
        addrFromCpu = '0;
        dataFromCpu = '0;
        rdEn        = 1'b0;
        wtEn        = 1'b0;
        dataFromMem = '0;
        mem_lat     = 0;
        for (int i = 0; i < NP; i++) begin
            c_rw[i]   = IDEL;
            c_addr[i] = '0;
            c_data[i] = '0;
            c_act[i]  = 1'b0;
        end
        model_reset();

        @(negedge clk);
        chk("reset_rwToMem",    rwToMem,    IDEL);
        chk("reset_addrToMem",  addrToMem,  '0);
        chk("reset_dataToMem",  dataToMem,  '0);
        chk("reset_grantIdx",   grantIdx,   NP - 1);
        chk("reset_busy",       busy,       1'b0);
        chk("reset_timeoutErr", timeoutErr, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            cyc_now = cyc;
            @(posedge clk);
            #1;
            drive_cores();
            drive_mem();
            @(negedge clk);
            if (rst_idx < 2 && cyc >= rst_at[rst_idx] && m_pend) begin
                mid_reset();
                rst_idx++;
            end
            check_and_advance();
        end

        chk("mid_resets_done", rst_idx, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single cache/memory request port among NPORT processor cores.
- Each core drives its own rw/addr/data request and waits for its rdEn/wtEn, exactly as it would with a private memory.
- Arbitration is round-robin with the grant locked for a whole transaction, plus a watchdog that aborts stalled accesses.
- Sits between the processor array and the cache; it is transparent to the cores apart from added latency.

Parameters:
- NPORT, 4, number of requesting cores (2..8).
- PORTW, 2, width of the grant index; must satisfy 2**PORTW >= NPORT.
- TIMEOUT, 255, maximum cycles to wait for memory rdEn/wtEn before aborting; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rwFromCpu  in  NPORT*IOSTATEWIDTH  per-port request (IDEL/RD/WT); port i occupies slice i.
- addrFromCpu  in  NPORT*ADDRWIDTH  per-port address.
- dataFromCpu  in  NPORT*WORDWIDTH  per-port write data.
- rdEnToCpu  out  NPORT  per-port read-done strobe.
- wtEnToCpu  out  NPORT  per-port write-done strobe.
- dataToCpu  out  WORDWIDTH  read data, broadcast to all ports.
- rwToMem  out  IOSTATEWIDTH  request to memory.
- addrToMem  out  ADDRWIDTH  address to memory.
- dataToMem  out  WORDWIDTH  write data to memory.
- rdEn  in  1  memory read-done.
- wtEn  in  1  memory write-done.
- dataFromMem  in  WORDWIDTH  memory read data.
- grantIdx  out  PORTW  index of the current or last granted port.
- busy  out  1  high while a transaction is outstanding.
- timeoutErr  out  1  sticky flag, set by a watchdog abort.

Behaviour:
- Reset (asynchronous): state=IDLE; rwToMem=IDEL; addrToMem=0; dataToMem=0; grantIdx=NPORT-1, so port 0 has first priority; busy=0; timeoutErr=0; watchdog count=0.
- Request: port i is requesting when its rw slice equals RD or WT. Any other encoding counts as no request.
- FSM states: IDLE, BUSY, RELEASE.
- IDLE:
  - Search ports starting at grantIdx+1 modulo NPORT; the first requester wins.
  - On a winner, at the clock edge: register grantIdx; latch the winner's rw/addr/data into rwToMem/addrToMem/dataToMem; busy=1; count=0; go to BUSY.
  - Latency: the request is seen in cycle N and rwToMem is valid from cycle N+1.
  - With no requester, stay in IDLE with all outputs held.
- BUSY:
  - Memory outputs stay stable. Changes on the granted port's inputs are ignored until release.
  - rdEnToCpu[grantIdx] = rdEn when rwToMem==RD; wtEnToCpu[grantIdx] = wtEn when rwToMem==WT. These are combinational, same cycle. All other strobe bits stay 0.
  - dataToCpu = dataFromMem, combinational, at all times.
  - On the matching enable at the edge: rwToMem=IDEL, busy=0, go to RELEASE.
  - A non-matching enable (wtEn during RD, or the reverse) is ignored.
  - Watchdog: count increments each BUSY cycle. If TIMEOUT!=0 and count reaches TIMEOUT without a matching enable: rwToMem=IDEL, timeoutErr=1, busy=0, go to RELEASE. No strobe is issued, so the requester keeps waiting; this mirrors processor ERR semantics.
- RELEASE:
  - Lasts exactly one cycle with no grant, giving the served core one edge to drop its rw to IDEL.
  - Then go to IDLE. The served port has the lowest priority in the next search.
- Back-to-back: one core can issue at most one transaction per 3 cycles plus memory latency. Under contention, every other requester is served before the same port is served again.
- Simultaneous events:
  - A request arriving during BUSY/RELEASE waits for IDLE; nothing is dropped, because the cores hold rw until acknowledged.
  - A matching enable in the same cycle the watchdog expires counts as completion: strobe issued, timeoutErr unchanged.
- Reset mid-transaction: immediate abort; rwToMem=IDEL; no strobes.
- timeoutErr is cleared only by reset.

Decomposition:
- IOSTATEWIDTH, IDEL, RD, WT, ADDRWIDTH and WORDWIDTH come from the shared def.v.
- Add MEMARB_IDLE/BUSY/RELEASE state codes (width 2) to def.v.
- Sub-module rr_picker: combinational round-robin priority search. Inputs: request vector and last grant index. Outputs: winner index and a valid bit. It is reusable for future bus arbiters.

Test Plan:
- Single read, NPORT=4: port 2 RD addr 0x10; memory asserts rdEn 3 cycles after rwToMem=RD with data 0xAB.
  -> rwToMem=RD one cycle after the request; rdEnToCpu=4'b0100 in the same cycle as rdEn; dataToCpu=0xAB; rwToMem=IDEL next edge; grantIdx=2.
- Contention: ports 0, 1 and 3 all request at cycle 0 and hold until served.
  -> Grants in order 0, 1, 3, each separated by one RELEASE cycle; no overlapping strobes.
- Fairness: port 0 re-requests immediately after each ack while port 1 requests continuously.
  -> Grants alternate 0, 1, 0, 1.
- Write: port 3 WT addr 0x20 data 0x55; wtEn after 2 cycles.
  -> dataToMem=0x55, addrToMem=0x20, wtEnToCpu=4'b1000.
  -> A rdEn pulse injected mid-transaction produces no strobe.
- Watchdog, TIMEOUT=8: memory never acknowledges.
  -> rwToMem returns to IDEL after 8 BUSY cycles; timeoutErr=1 and stays set.
  -> The next requester is served normally.
- Asynchronous reset asserted mid-BUSY without a clock edge.
  -> rwToMem=IDEL, busy=0, strobes 0 immediately; after release, port 0 has priority.
